calc_seq_fsm: RTL and testbench

Parametrised sequencing controller for the calculator datapath; successor to the fixed 5-state controller.
- Loads NUM_OPS operand registers one per cycle from the shared operand bus, plus the function register.
- Kicks the compute unit and waits for its done handshake, with a timeout.
- Captures result, remainder and done flag, then holds them until restart or clear.
- Moore outputs drive register write-enables and active-low register resets (*_rst_o = 0 holds the register in reset).

---
 rtl/calc_seq_pkg.sv | 24 ++
 rtl/calc_seq_timer.sv | 38 +++
 rtl/calc_seq_fsm.sv | 183 ++++++++++++++++++
 tb/tb_calc_seq_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_seq_pkg.sv
// Shared types and width helpers for the calculator sequencing controller.
package calc_seq_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StKick  = 3'd2,
    StWait  = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

  function automatic int unsigned idx_width(input int unsigned num_ops);
    return (num_ops > 1) ? $clog2(num_ops) : 1;
  endfunction

  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/calc_seq_timer.sv
// WAIT-phase cycle counter: synchronous clear/enable, terminal count at TIMEOUT_CYCLES-1.
module calc_seq_timer
  import calc_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = timer_width(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(TIMEOUT_CYCLES - 1));

  // Holds at terminal count; the controller leaves WAIT before any wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/calc_seq_fsm.sv
// Calculator sequencing controller: operand/function load, compute kick, wait, capture.
// Optional result chaining into operand 0 is enabled by defining CALC_SEQ_CHAIN_EN.
module calc_seq_fsm
  import calc_seq_pkg::*;
#(
  parameter int unsigned NUM_OPS        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               exec_done_i,
`ifdef CALC_SEQ_CHAIN_EN
  input  logic               chain_i,
  output logic               op0_sel_res_o,
`endif
  output logic [NUM_OPS-1:0] op_we_o,
  output logic               op_rst_o,
  output logic               fct_we_o,
  output logic               fct_rst_o,
  output logic               exec_start_o,
  output logic               res_we_o,
  output logic               rem_we_o,
  output logic               done_we_o,
  output logic               res_rst_o,
  output logic               rem_rst_o,
  output logic               done_rst_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned IdxW = idx_width(NUM_OPS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OPS - 1);

  state_e        state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic          tmr_tc;

`ifdef CALC_SEQ_CHAIN_EN
  logic chain_q, chain_d;
`endif

  calc_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i (clock_i),
    .rst_ni(reset_i),
    .clr_i (state_q != StWait),
    .en_i  (state_q == StWait),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef CALC_SEQ_CHAIN_EN
    chain_d = chain_q;
`endif
    if (clear_i) begin
      state_d = StIdle;
      idx_d   = '0;
`ifdef CALC_SEQ_CHAIN_EN
      chain_d = 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StLoad;
            idx_d   = '0;
`ifdef CALC_SEQ_CHAIN_EN
            chain_d = 1'b0;
`endif
          end
        end
        StLoad: begin
          if (idx_q == LastIdx) begin
            state_d = StKick;
            idx_d   = '0;
`ifdef CALC_SEQ_CHAIN_EN
            chain_d = 1'b0;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        StKick:  state_d = StWait;
        StWait: begin
          if (exec_done_i) begin
            state_d = StWrite;
          end else if (tmr_tc) begin
            state_d = StErr;
          end
        end
        StWrite: state_d = StDone;
        StDone: begin
          if (start_i) begin
            state_d = StLoad;
            idx_d   = '0;
`ifdef CALC_SEQ_CHAIN_EN
            chain_d = chain_i;
`endif
          end
        end
        StErr:   state_d = StErr;
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Moore decode: outputs depend on registered state only.
  always_comb begin
    op_we_o      = '0;
    op_rst_o     = 1'b0;
    fct_we_o     = 1'b0;
    fct_rst_o    = 1'b0;
    exec_start_o = 1'b0;
    res_we_o     = 1'b0;
    rem_we_o     = 1'b0;
    done_we_o    = 1'b0;
    res_rst_o    = 1'b0;
    rem_rst_o    = 1'b0;
    done_rst_o   = 1'b0;
    busy_o       = 1'b0;
    err_o        = 1'b0;
`ifdef CALC_SEQ_CHAIN_EN
    op0_sel_res_o = 1'b0;
`endif
    if (state_q inside {StLoad, StKick, StWait, StWrite, StDone, StErr}) begin
      op_rst_o  = 1'b1;
      fct_rst_o = 1'b1;
    end
    if (state_q inside {StLoad, StKick, StWait, StWrite, StDone}) begin
      res_rst_o  = 1'b1;
      rem_rst_o  = 1'b1;
      done_rst_o = 1'b1;
    end
    case (state_q)
      StLoad: begin
        op_we_o  = NUM_OPS'(1) << idx_q;
        fct_we_o = (idx_q == '0);
        busy_o   = 1'b1;
`ifdef CALC_SEQ_CHAIN_EN
        op0_sel_res_o = chain_q && (idx_q == '0);
`endif
      end
      StKick: begin
        exec_start_o = 1'b1;
        busy_o       = 1'b1;
      end
      StWait:  busy_o = 1'b1;
      StWrite: begin
        res_we_o  = 1'b1;
        rem_we_o  = 1'b1;
        done_we_o = 1'b1;
        busy_o    = 1'b1;
      end
      StErr:   err_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
`ifdef CALC_SEQ_CHAIN_EN
      chain_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef CALC_SEQ_CHAIN_EN
      chain_q <= chain_d;
`endif
    end
  end

endmodule

// File: tb/tb_calc_seq_fsm.sv
// Self-checking bench for calc_seq_fsm (NUM_OPS=3, TIMEOUT_CYCLES=8): vector table,
// directed corner sequences and randomized traffic against a run-position reference model.
module tb_calc_seq_fsm;

  localparam int N = 3;
  localparam int T = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start, clear, exec_done, chain;
  logic [N-1:0] op_we;
  logic op_rst, fct_we, fct_rst, exec_start, res_we, rem_we, done_we;
  logic res_rst, rem_rst, done_rst, busy, err, sel;

  calc_seq_fsm #(
    .NUM_OPS       (N),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock_i      (clk),
    .reset_i      (reset_n),
    .start_i      (start),
    .clear_i      (clear),
    .exec_done_i  (exec_done),
`ifdef CALC_SEQ_CHAIN_EN
    .chain_i      (chain),
    .op0_sel_res_o(sel),
`endif
    .op_we_o      (op_we),
    .op_rst_o     (op_rst),
    .fct_we_o     (fct_we),
    .fct_rst_o    (fct_rst),
    .exec_start_o (exec_start),
    .res_we_o     (res_we),
    .rem_we_o     (rem_we),
    .done_we_o    (done_we),
    .res_rst_o    (res_rst),
    .rem_rst_o    (rem_rst),
    .done_rst_o   (done_rst),
    .busy_o       (busy),
    .err_o        (err)
  );

`ifndef CALC_SEQ_CHAIN_EN
  assign sel = 1'b0;
`endif

  typedef struct packed {
    logic [N-1:0] op_we;
    logic op_rst, fct_we, fct_rst, exec_start, res_we, rem_we, done_we;
    logic res_rst, rem_rst, done_rst, busy, err, sel;
  } out_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic out_t dut_out();
    return '{op_we, op_rst, fct_we, fct_rst, exec_start, res_we, rem_we, done_we,
             res_rst, rem_rst, done_rst, busy, err, sel};
  endfunction

  // Reference: m_run counts cycles since a start was accepted (-1 when not running):
  // 0..N-1 loading operand m_run, N kick, beyond N waiting.
  int m_run   = -1;
  bit m_wr    = 1'b0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;
  bit m_chain = 1'b0;

  function automatic out_t model_out();
    out_t o = '0;
    if (m_run >= 0 || m_wr || m_done || m_err) begin
      o.op_rst  = 1'b1;
      o.fct_rst = 1'b1;
    end
    if (m_run >= 0 || m_wr || m_done) begin
      o.res_rst  = 1'b1;
      o.rem_rst  = 1'b1;
      o.done_rst = 1'b1;
    end
    if (m_run >= 0 || m_wr) o.busy = 1'b1;
    if (m_run >= 0 && m_run < N) begin
      o.op_we  = N'(1) << m_run;
      o.fct_we = (m_run == 0);
      o.sel    = m_chain && (m_run == 0);
    end
    if (m_run == N) o.exec_start = 1'b1;
    if (m_wr) begin
      o.res_we  = 1'b1;
      o.rem_we  = 1'b1;
      o.done_we = 1'b1;
    end
    if (m_err) o.err = 1'b1;
    return o;
  endfunction

  task automatic model_step();
    if (!reset_n || clear) begin
      m_run = -1; m_wr = 0; m_done = 0; m_err = 0; m_chain = 0;
    end else if (m_wr) begin
      m_wr = 0; m_done = 1;
    end else if (m_run > N) begin
      if (exec_done) begin
        m_run = -1; m_wr = 1;
      end else if (m_run - N - 1 == T - 1) begin
        m_run = -1; m_err = 1;
      end else begin
        m_run++;
      end
    end else if (m_run >= 0) begin
      if (m_run == N - 1) m_chain = 0;
      m_run++;
    end else if (!m_err && start) begin
      m_chain = m_done && chain;
      m_done  = 0;
      m_run   = 0;
    end
  endtask

  task automatic step(input string name);
    model_step();
    @(posedge clk);
    #1;
    check(name, 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic go_wait();
    start = 1; step("ld0");
    start = 0; step("ld1");
    step("ld2");
    step("kick");
    step("w0");
  endtask

  typedef struct {
    logic rst_n, st, clr, dn;
    logic [N-1:0] op_we;
    logic fct_we, kick, res_we, busy, err, res_rst;
  } vec_t;

  vec_t tbl[14];

  initial begin
    reset_n = 0; start = 0; clear = 0; exec_done = 0; chain = 0;
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset, nominal run with done 3 cycles after kick, then clear+start in DONE.
    for (int i = 0; i < 14; i++) begin
      reset_n = tbl[i].rst_n; start = tbl[i].st; clear = tbl[i].clr; exec_done = tbl[i].dn;
      step($sformatf("tbl%0d_full", i));
      check($sformatf("tbl%0d", i),
            32'({op_we, fct_we, exec_start, res_we, busy, err, res_rst}),
            32'({tbl[i].op_we, tbl[i].fct_we, tbl[i].kick, tbl[i].res_we, tbl[i].busy,
                 tbl[i].err, tbl[i].res_rst}));
    end
    reset_n = 1; start = 0; clear = 0; exec_done = 0;

    // Timeout after 8 WAIT cycles, start ignored in ERR, clear recovers.
    go_wait();
    repeat (T - 1) step("wait");
    check("wait8_busy", 32'(busy), 32'd1);
    step("to_err");
    check("err_flag", 32'({err, res_rst, busy, op_rst}), 32'b1001);
    start = 1; step("err_start");
    check("err_ignores_start", 32'({err, busy}), 32'b10);
    start = 0; clear = 1; step("err_clear");
    clear = 0;
    check("err_clear_idle", 32'({busy, err, op_rst}), 32'd0);

    // exec_done on the last WAIT cycle beats the timeout.
    go_wait();
    repeat (T - 1) step("wait");
    exec_done = 1; step("late_done");
    exec_done = 0;
    check("late_done_write", 32'({res_we, err}), 32'b10);
    step("late_done_done");
    check("late_done_state", 32'({busy, res_rst, err}), 32'b010);
    clear = 1; step("clr"); clear = 0;

    // Clear mid-load stops operand writes immediately.
    start = 1; step("ab_ld0");
    start = 0; step("ab_ld1");
    check("abort_ld1", 32'(op_we), 32'b010);
    clear = 1; step("abort_clr");
    clear = 0;
    check("abort_idle", 32'({op_we, busy}), 32'd0);
    step("abort_after");
    check("abort_quiet", 32'(op_we), 32'd0);

    // Reset during WAIT.
    go_wait();
    step("w1");
    reset_n = 0; step("rst_wait");
    reset_n = 1;
    check("rst_wait_idle", 32'({busy, err, res_rst}), 32'd0);

`ifdef CALC_SEQ_CHAIN_EN
    go_wait();
    exec_done = 1; step("c_wr"); exec_done = 0;
    step("c_done");
    start = 1; chain = 1; step("c_ld0");
    start = 0; chain = 0;
    check("chain_sel_ld0", 32'({sel, op_we}), 32'b1001);
    step("c_ld1");
    check("chain_sel_ld1", 32'(sel), 32'd0);
    step("c_ld2"); step("c_kick"); step("c_w0");
    exec_done = 1; step("c_wr2"); exec_done = 0;
    step("c_done2");
    start = 1; chain = 0; step("nc_ld0");
    start = 0;
    check("nochain_ld0", 32'(sel), 32'd0);
    clear = 1; step("c_clr"); clear = 0;
    start = 1; chain = 1; step("idle_chain");
    start = 0; chain = 0;
    check("idle_never_chains", 32'({sel, op_we}), 32'b0001);
    clear = 1; step("c_clr2"); clear = 0;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_n   = ($urandom_range(99) >= 2);
      clear     = ($urandom_range(99) < 3);
      start     = ($urandom_range(99) < 30);
      exec_done = ($urandom_range(99) < 12);
`ifdef CALC_SEQ_CHAIN_EN
      chain     = $urandom_range(1);
`endif
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
